// File: rtl/sram_bus_ctrl.sv
// ---------------------------------------------------------------------------
// sram_bus_ctrl : CPU-to-asynchronous-SRAM bus controller with wait states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_bus_ctrl #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  inout  wire  [DATA_WIDTH-1:0] cpu_data,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  output logic                  cpu_ready,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_dq,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("sram_bus_ctrl: WAIT_CYCLES must lie in 1..15");
    end
  endgenerate

  localparam logic [3:0] c_wcnt_load = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_wcnt;
  logic                  r_dir;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic                  w_cpu_drive;
  logic                  w_sram_drive;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write wins when both request levels are high.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cpu_write) begin
          w_state_nxt = S_WRITE;
        end else if (cpu_read) begin
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (r_wcnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WRITE: begin
        if (r_wcnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wcnt  <= 4'd0;
      r_dir   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
    end else begin
      r_ce_n <= !((w_state_nxt == S_READ) || (w_state_nxt == S_WRITE));
      r_oe_n <= (w_state_nxt != S_READ);
      r_we_n <= (w_state_nxt != S_WRITE);
      case (r_state)
        S_IDLE: begin
          if (cpu_write) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_data;
            r_dir   <= 1'b1;
            r_wcnt  <= c_wcnt_load;
          end else if (cpu_read) begin
            r_addr <= cpu_addr;
            r_dir  <= 1'b0;
            r_wcnt <= c_wcnt_load;
          end
        end
        S_READ: begin
          if (r_wcnt == 4'd0) begin
            r_rdata <= sram_dq;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        S_WRITE: begin
          if (r_wcnt != 4'd0) begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_cpu_drive  = (r_state == S_DONE) && !r_dir && cpu_read;
  assign w_sram_drive = (r_state == S_WRITE) || ((r_state == S_DONE) && r_dir);

  assign cpu_data  = w_cpu_drive  ? r_rdata : {DATA_WIDTH{1'bz}};
  assign sram_dq   = w_sram_drive ? r_wdata : {DATA_WIDTH{1'bz}};

  assign cpu_ready = (r_state == S_DONE) ||
                     ((r_state == S_IDLE) && !cpu_read && !cpu_write);
  assign busy      = (r_state != S_IDLE);
  assign sram_addr = r_addr;
  assign sram_ce_n = r_ce_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_ctrl : directed self-checking bench for sram_bus_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_bus_ctrl;

  logic        clk;
  logic        reset;
  logic [19:0] cpu_addr;
  logic        cpu_read;
  logic        cpu_write;
  logic        cpu_ready;
  logic        busy;
  logic [19:0] sram_addr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  wire  [15:0] cpu_data;
  wire  [15:0] sram_dq;

  logic        cpu_wr_en;
  logic [15:0] cpu_wr_val;
  logic        cpu_probe;
  logic        sram_probe;
  logic [15:0] mem [0:63];
  logic        sram_out;

  int checks;
  int errors;

  // Alternate builds with minimum and maximum wait states
  logic        rd1, rd15;
  logic        ready1, busy1, ce1, oe1, we1;
  logic        ready15, busy15, ce15, oe15, we15;
  logic [19:0] addr1, addr15;
  wire  [15:0] cd1, dq1, cd15, dq15;

  sram_bus_ctrl #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_ready(cpu_ready),
    .busy(busy), .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  sram_bus_ctrl #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .cpu_addr(20'h0), .cpu_data(cd1),
    .cpu_read(rd1), .cpu_write(1'b0), .cpu_ready(ready1),
    .busy(busy1), .sram_addr(addr1), .sram_dq(dq1),
    .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1)
  );

  sram_bus_ctrl #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .reset(reset), .cpu_addr(20'h0), .cpu_data(cd15),
    .cpu_read(rd15), .cpu_write(1'b0), .cpu_ready(ready15),
    .busy(busy15), .sram_addr(addr15), .sram_dq(dq15),
    .sram_ce_n(ce15), .sram_oe_n(oe15), .sram_we_n(we15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU side driver; the probe drives zero to reveal any opposing driver.
  assign cpu_data = (cpu_wr_en || cpu_probe) ? (cpu_probe ? 16'h0000 : cpu_wr_val) : 16'hzzzz;

  // Asynchronous SRAM model indexed by the low address bits
  assign sram_out = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_dq  = (sram_out || sram_probe) ? (sram_probe ? 16'h0000 : mem[sram_addr[5:0]]) : 16'hzzzz;

  always @(posedge clk) begin
    if (reset) begin
      mem[6'h23] <= 16'hBEEF;
      mem[6'h06] <= 16'hCAFE;
    end else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr[5:0]] <= sram_dq;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic probe_cpu(input string tag);
    cpu_probe = 1'b1;
    #1;
    check(tag, {16'h0, cpu_data}, 32'h0);
    cpu_probe = 1'b0;
  endtask

  task automatic probe_sram(input string tag);
    sram_probe = 1'b1;
    #1;
    check(tag, {16'h0, sram_dq}, 32'h0);
    sram_probe = 1'b0;
  endtask

  // Contention monitor: whenever the bench drives a bus, it must read back unaltered.
  always @(negedge clk) begin
    if (!reset && sram_out && !sram_probe)
      check("sram_contention", {16'h0, sram_dq}, {16'h0, mem[sram_addr[5:0]]});
    if (!reset && cpu_wr_en && !cpu_probe)
      check("cpu_contention", {16'h0, cpu_data}, {16'h0, cpu_wr_val});
  end

  // One W=2 access: cycle 0 in IDLE, cycles 1..2 access, cycle 3 DONE.
  task automatic access(input bit wr, input bit rd, input logic [19:0] a,
                        input logic [15:0] wd, input logic [15:0] rd_exp);
    bit rd_only;
    bit act;
    rd_only    = rd && !wr;
    cpu_addr   = a;
    cpu_write  = wr;
    cpu_read   = rd;
    cpu_wr_en  = wr;
    cpu_wr_val = wd;
    for (int c = 0; c < 4; c++) begin
      act = (c == 1) || (c == 2);
      @(negedge clk);
      check($sformatf("ready_c%0d", c), {31'h0, cpu_ready}, {31'h0, (c == 3)});
      check($sformatf("busy_c%0d", c), {31'h0, busy}, {31'h0, (c != 0)});
      check($sformatf("ce_n_c%0d", c), {31'h0, sram_ce_n}, {31'h0, !act});
      check($sformatf("oe_n_c%0d", c), {31'h0, sram_oe_n}, {31'h0, !(act && rd_only)});
      check($sformatf("we_n_c%0d", c), {31'h0, sram_we_n}, {31'h0, !(act && wr)});
      if (c != 0)
        check($sformatf("sram_addr_c%0d", c), {12'h0, sram_addr}, {12'h0, a});
      if (wr && c != 0)
        check($sformatf("sram_dq_wr_c%0d", c), {16'h0, sram_dq}, {16'h0, wd});
      if (c == 0 || (rd_only && c == 3))
        probe_sram($sformatf("sram_dq_hiz_c%0d", c));
      if (!wr && c < 3)
        probe_cpu($sformatf("cpu_data_hiz_c%0d", c));
      if (rd_only && c == 3)
        check("cpu_data_rd", {16'h0, cpu_data}, {16'h0, rd_exp});
      @(posedge clk);
      #1;
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    cpu_addr   = '0;
    cpu_read   = 1'b0;
    cpu_write  = 1'b0;
    cpu_wr_en  = 1'b0;
    cpu_wr_val = '0;
    cpu_probe  = 1'b0;
    sram_probe = 1'b0;
    rd1        = 1'b0;
    rd15       = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ready", {31'h0, cpu_ready}, 32'h1);
    check("rst_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
    check("rst_addr", {12'h0, sram_addr}, 32'h0);
    probe_sram("rst_sram_hiz");
    probe_cpu("rst_cpu_hiz");
    @(posedge clk);
    #1;
    reset = 1'b0;

    access(1'b0, 1'b1, 20'h00123, 16'h0000, 16'hBEEF);
    access(1'b1, 1'b0, 20'hFFFFF, 16'h1234, 16'h0000);
    access(1'b0, 1'b1, 20'hFFFFF, 16'h0000, 16'h1234);
    @(negedge clk);
    check("idle_ready", {31'h0, cpu_ready}, 32'h1);
    check("idle_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;

    // Back-to-back: the read is raised right at the DONE->IDLE edge.
    access(1'b1, 1'b0, 20'h00005, 16'h0001, 16'h0000);
    access(1'b0, 1'b1, 20'h00006, 16'h0000, 16'hCAFE);
    access(1'b0, 1'b1, 20'h00005, 16'h0000, 16'h0001);

    // Both request levels high: must be a write.
    access(1'b1, 1'b1, 20'h00007, 16'hA5A5, 16'h0000);
    access(1'b0, 1'b1, 20'h00007, 16'h0000, 16'hA5A5);

    // Reset in cycle 1 of a write
    cpu_addr   = 20'h00009;
    cpu_write  = 1'b1;
    cpu_wr_en  = 1'b1;
    cpu_wr_val = 16'h5555;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mw_we_n_low", {31'h0, sram_we_n}, 32'h0);
    cpu_write = 1'b0;
    cpu_wr_en = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("mw_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
    check("mw_busy", {31'h0, busy}, 32'h0);
    check("mw_ready", {31'h0, cpu_ready}, 32'h1);
    check("mw_addr", {12'h0, sram_addr}, 32'h0);
    probe_sram("mw_sram_hiz");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mw_post_busy", {31'h0, busy}, 32'h0);
    check("mw_post_ready", {31'h0, cpu_ready}, 32'h1);
    check("mw_post_ce_n", {31'h0, sram_ce_n}, 32'h1);

    // W=1: ready in cycle 2
    @(posedge clk);
    #1;
    rd1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("w1_ready_c%0d", c), {31'h0, ready1}, {31'h0, (c == 2)});
      @(posedge clk);
      #1;
    end
    rd1 = 1'b0;
    @(negedge clk);
    check("w1_idle_busy", {31'h0, busy1}, 32'h0);

    // W=15: ready in cycle 16
    @(posedge clk);
    #1;
    rd15 = 1'b1;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      check($sformatf("w15_ready_c%0d", c), {31'h0, ready15}, {31'h0, (c == 16)});
      if (c == 15)
        check("w15_oe_n_c15", {31'h0, oe15}, 32'h0);
      @(posedge clk);
      #1;
    end
    rd15 = 1'b0;
    @(negedge clk);
    check("w15_idle_busy", {31'h0, busy15}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
